// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline definitions: datapath width, register address width
// and the writeback-select encodings used by wb_mux.
package rv32_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_DMEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC   = 2'b10;

endpackage

// File: rtl/wb_mux.sv
// 3:1 writeback-value select (ALU / load data / link address). Also used by
// the forwarding unit's MEM-stage path, so it carries no state.
module wb_mux
  import rv32_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] alu,
  input  logic [W-1:0] dmem,
  input  logic [W-1:0] pc_next,
  output logic [W-1:0] wdata
);

  // NOTE: a default assignment ahead of the case keeps this purely combinational (no latch).
  always_comb begin
    wdata = alu;
    case (sel)
      WB_SEL_DMEM: wdata = dmem;
      WB_SEL_PC:   wdata = pc_next;
      default:     wdata = alu;  // 00 and 11 both select the ALU result
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// RV32I writeback stage and 32 x XLEN integer register file with two
// combinational read ports. Define RF_BYPASS_EN for write-through reads.
module wb_regfile #(
  parameter int XLEN = rv32_pkg::XLEN,
  parameter int NREG = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    W_wb,
  input  logic                          W_wen_rf,
  input  logic [XLEN-1:0]               W_ALUresult,
  input  logic [XLEN-1:0]               W_DMEMresult,
  input  logic [XLEN-1:0]               W_PC_next,
  input  logic [rv32_pkg::REG_ADDR_W-1:0] W_rd,
  input  logic [rv32_pkg::REG_ADDR_W-1:0] D_rs1,
  input  logic [rv32_pkg::REG_ADDR_W-1:0] D_rs2,
  output logic [XLEN-1:0]               D_rdata1,
  output logic [XLEN-1:0]               D_rdata2,
  output logic [XLEN-1:0]               W_wdata,
  output logic                          W_commit
);

  import rv32_pkg::*;

  logic [XLEN-1:0] regs [NREG];

  wb_mux #(.W(XLEN)) u_wb_mux (
    .sel     (W_wb),
    .alu     (W_ALUresult),
    .dmem    (W_DMEMresult),
    .pc_next (W_PC_next),
    .wdata   (W_wdata)
  );

  assign W_commit = W_wen_rf && (W_rd != '0);

  // NOTE: this array is reset on purpose; the pipeline relies on every register reading 0 after reset.
  // NOTE: state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (W_commit) begin
      regs[W_rd] <= W_wdata;
    end
  end

  // x0 and an active reset both force zero, overriding any bypass.
  always_comb begin
    D_rdata1 = regs[D_rs1];
`ifdef RF_BYPASS_EN
    if (W_commit && (D_rs1 == W_rd)) D_rdata1 = W_wdata;
`endif
    if (!rst_n || (D_rs1 == '0)) D_rdata1 = '0;
  end

  always_comb begin
    D_rdata2 = regs[D_rs2];
`ifdef RF_BYPASS_EN
    if (W_commit && (D_rs2 == W_rd)) D_rdata2 = W_wdata;
`endif
    if (!rst_n || (D_rs2 == '0)) D_rdata2 = '0;
  end

endmodule
